// File: rtl/multdiv_ctrl_pkg.sv
// Shared opcode constants and FSM encoding for the execute-stage multdiv controller.
package processor_defs;

  localparam logic [4:0] OP_ALU    = 5'b00000;
  localparam logic [4:0] ALUOP_MUL = 5'b00110;
  localparam logic [4:0] ALUOP_DIV = 5'b00111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } md_state_e;

endpackage

// File: rtl/multdiv_ctrl_watchdog.sv
// Cycle counter with clear/enable; tc flags the last allowed WAIT cycle.
module md_watchdog #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Execute-stage mul/div controller: issues a start pulse, stalls until the unit
// answers or the watchdog fires, then presents a one-cycle result packet.
module multdiv_ctrl
  import processor_defs::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  x_op,
  input  logic [4:0]  x_aluop,
  input  logic [4:0]  x_rd,
  input  logic        flush,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        res_ovf,
  output logic [4:0]  res_rd,
  output logic        res_is_div
);

  md_state_e  state;
  logic       is_mul, is_div, is_md;
  logic [4:0] rd_q;
  logic       div_q;
  logic       wd_tc;

  assign is_mul = (x_op == OP_ALU) && (x_aluop == ALUOP_MUL);
  assign is_div = (x_op == OP_ALU) && (x_aluop == ALUOP_DIV);
  assign is_md  = is_mul | is_div;

  md_watchdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wd (
    .clock (clock),
    .reset (reset),
    .clr   (state != ST_WAIT),
    .en    (state == ST_WAIT),
    .tc    (wd_tc)
  );

  // Detection stall must be visible in the same cycle, so it is the one
  // combinational output; gated by reset so everything reads 0 during reset.
  assign stall = ~reset & ((state == ST_START) || (state == ST_WAIT) ||
                           ((state == ST_IDLE) && is_md && !flush));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      rd_q       <= '0;
      div_q      <= 1'b0;
      ctrl_mult  <= 1'b0;
      ctrl_div   <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_ovf    <= 1'b0;
      res_rd     <= '0;
      res_is_div <= 1'b0;
    end else begin
      ctrl_mult <= 1'b0;
      ctrl_div  <= 1'b0;
      res_valid <= 1'b0;
      case (state)
        ST_IDLE: if (is_md && !flush) begin
          state     <= ST_START;
          rd_q      <= x_rd;
          div_q     <= is_div;
          ctrl_mult <= ~is_div;
          ctrl_div  <= is_div;
        end
        ST_START: state <= flush ? ST_IDLE : ST_WAIT;
        ST_WAIT: begin
          // res_* is only touched on completion so a squashed op leaves it intact
          if (flush) begin
            state <= ST_IDLE;
          end else if (md_ready || wd_tc) begin
            state      <= ST_DONE;
            res_valid  <= 1'b1;
            res_data   <= md_ready ? md_result : 32'd0;
            res_ovf    <= md_ready ? md_exception : 1'b1;
            res_rd     <= rd_q;
            res_is_div <= div_q;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: cycle-accurate sequences with hand-computed expectations.
module tb_multdiv_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  x_op, x_aluop, x_rd;
  logic        flush, md_ready, md_exception;
  logic [31:0] md_result;
  logic        ctrl_mult, ctrl_div, stall, res_valid, res_ovf, res_is_div;
  logic [31:0] res_data;
  logic [4:0]  res_rd;

  int n_chk = 0;
  int n_err = 0;

  // per-run observations
  int n_mult, n_div, mult_cyc, div_cyc, n_both, stall_cnt, last_stall;
  int n_valid, valid_cyc, valid_cyc2;
  logic [31:0] vdata;
  logic        vovf, vdiv;
  logic [4:0]  vrd;

  multdiv_ctrl #(.TIMEOUT(64), .CNT_W(7)) dut (
    .clock(clock), .reset(reset), .x_op(x_op), .x_aluop(x_aluop), .x_rd(x_rd),
    .flush(flush), .md_ready(md_ready), .md_exception(md_exception),
    .md_result(md_result), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
    .stall(stall), .res_valid(res_valid), .res_data(res_data), .res_ovf(res_ovf),
    .res_rd(res_rd), .res_is_div(res_is_div)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_nop();
    x_op = 5'b00001; x_aluop = 5'b00000; x_rd = 5'd0;
  endtask

  // Runs up to two mul/div instructions through X starting at cycle 0.
  // An instruction leaves X after a cycle with stall low, or when flushed.
  task automatic run_op(input int n_ins, input bit d0, input logic [4:0] rd0,
                        input bit d1, input logic [4:0] rd1,
                        input int r0, input int r1, input logic [31:0] data,
                        input bit exc, input int flush_cyc, input int ncyc);
    int idx = 0;
    n_mult = 0; n_div = 0; mult_cyc = -1; div_cyc = -1; n_both = 0;
    stall_cnt = 0; last_stall = -1; n_valid = 0; valid_cyc = -1; valid_cyc2 = -1;
    for (int c = 0; c < ncyc; c++) begin
      if (idx < n_ins) begin
        x_op = 5'b00000;
        x_aluop = ((idx == 0) ? d0 : d1) ? 5'b00111 : 5'b00110;
        x_rd = (idx == 0) ? rd0 : rd1;
      end else set_nop();
      md_ready = (c == r0) || (c == r1);
      md_result = data; md_exception = exc;
      flush = (c == flush_cyc);
      @(negedge clock);
      if (ctrl_mult) begin n_mult++; if (mult_cyc < 0) mult_cyc = c; end
      if (ctrl_div)  begin n_div++;  if (div_cyc < 0)  div_cyc = c;  end
      if (ctrl_mult && ctrl_div) n_both++;
      if (stall) begin stall_cnt++; last_stall = c; end
      if (res_valid) begin
        n_valid++;
        if (valid_cyc < 0) valid_cyc = c;
        valid_cyc2 = c;
        vdata = res_data; vovf = res_ovf; vrd = res_rd; vdiv = res_is_div;
      end
      if (idx < n_ins && (flush || !stall)) idx++;
      @(posedge clock); #1;
    end
    flush = 1'b0; md_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; set_nop(); flush = 0; md_ready = 0; md_exception = 0; md_result = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_data", res_data, 32'd0);
    chk("rst_rd", {27'd0, res_rd}, 32'd0);
    reset = 1'b0;

    // mul rd=5, ready at cycle 34
    run_op(1, 0, 5'd5, 0, 5'd0, 34, -1, 32'h0000_0A00, 0, -1, 40);
    chk("t1_mult_cyc", mult_cyc, 1);
    chk("t1_n_mult", n_mult, 1);
    chk("t1_n_div", n_div, 0);
    chk("t1_stall_cnt", stall_cnt, 35);
    chk("t1_last_stall", last_stall, 34);
    chk("t1_n_valid", n_valid, 1);
    chk("t1_valid_cyc", valid_cyc, 35);
    chk("t1_data", vdata, 32'h0000_0A00);
    chk("t1_ovf", {31'd0, vovf}, 32'd0);
    chk("t1_rd", {27'd0, vrd}, 32'd5);
    chk("t1_isdiv", {31'd0, vdiv}, 32'd0);
    chk("t1_hold_data", res_data, 32'h0000_0A00);

    // div rd=7, div-by-zero reported on the third WAIT cycle
    run_op(1, 1, 5'd7, 0, 5'd0, 4, -1, 32'hFFFF_FFFF, 1, -1, 10);
    chk("t2_div_cyc", div_cyc, 1);
    chk("t2_n_mult", n_mult, 0);
    chk("t2_n_valid", n_valid, 1);
    chk("t2_valid_cyc", valid_cyc, 5);
    chk("t2_ovf", {31'd0, vovf}, 32'd1);
    chk("t2_isdiv", {31'd0, vdiv}, 32'd1);
    chk("t2_rd", {27'd0, vrd}, 32'd7);

    // mul rd=9, unit never answers: 64 WAIT cycles (2..65), DONE at 66
    run_op(1, 0, 5'd9, 0, 5'd0, -1, -1, 32'h1234_5678, 0, -1, 72);
    chk("t3_valid_cyc", valid_cyc, 66);
    chk("t3_n_valid", n_valid, 1);
    chk("t3_data", vdata, 32'd0);
    chk("t3_ovf", {31'd0, vovf}, 32'd1);
    chk("t3_stall_cnt", stall_cnt, 66);
    chk("t3_last_stall", last_stall, 65);

    // mul rd=3 flushed at cycle 10 in WAIT; late ready at 20 is ignored
    run_op(1, 0, 5'd3, 0, 5'd0, 20, -1, 32'hDEAD_BEEF, 0, 10, 30);
    chk("t4_n_valid", n_valid, 0);
    chk("t4_last_stall", last_stall, 10);
    chk("t4_stall_cnt", stall_cnt, 11);
    chk("t4_keep_data", res_data, 32'd0);
    chk("t4_keep_ovf", {31'd0, res_ovf}, 32'd1);
    chk("t4_keep_rd", {27'd0, res_rd}, 32'd9);

    // back-to-back mul rd=4 (ready 3, DONE 4) then div rd=12 (detect 5, ready 8, DONE 9)
    run_op(2, 0, 5'd4, 1, 5'd12, 3, 8, 32'h0000_0042, 0, -1, 14);
    chk("t5_n_mult", n_mult, 1);
    chk("t5_n_div", n_div, 1);
    chk("t5_mult_cyc", mult_cyc, 1);
    chk("t5_div_cyc", div_cyc, 6);
    chk("t5_n_valid", n_valid, 2);
    chk("t5_valid1", valid_cyc, 4);
    chk("t5_valid2", valid_cyc2, 9);
    chk("t5_rd2", {27'd0, vrd}, 32'd12);
    chk("t5_isdiv2", {31'd0, vdiv}, 32'd1);
    chk("ctrl_exclusive", n_both, 0);

    // async reset in the middle of WAIT
    x_op = 5'b00000; x_aluop = 5'b00110; x_rd = 5'd6;
    repeat (4) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("t6_stall", {31'd0, stall}, 32'd0);
    chk("t6_ctrl", {30'd0, ctrl_mult, ctrl_div}, 32'd0);
    chk("t6_valid", {31'd0, res_valid}, 32'd0);
    chk("t6_data", res_data, 32'd0);
    chk("t6_rd", {27'd0, res_rd}, 32'd0);
    chk("t6_isdiv", {31'd0, res_is_div}, 32'd0);
    set_nop();
    @(posedge clock); #1 reset = 1'b0;
    run_op(1, 0, 5'd6, 0, 5'd0, 4, -1, 32'h0000_1234, 0, -1, 8);
    chk("t6_valid_cyc", valid_cyc, 5);
    chk("t6_after_data", vdata, 32'h0000_1234);
    chk("t6_after_rd", {27'd0, vrd}, 32'd6);
    chk("t6_mult_cyc", mult_cyc, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Execute-stage controller for the multi-cycle multiplier/divider. It sits directly upstream of the exception checker.
- Detects mul/div in X, issues a one-cycle start pulse to the multdiv unit, and stalls the pipeline until the unit reports ready (or a watchdog expires).
- Presents a one-cycle result packet: 32-bit result, overflow flag, and destination register.
- The overflow flag drives the exception checker's multdiv_ovf input, together with the OP/ALUOP of the completing instruction.

Parameters:
- TIMEOUT, 64, max cycles in WAIT before forced completion with overflow; must be ≥ 2.
- CNT_W, 7, counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- x_op  in  5  opcode of instruction in X.
- x_aluop  in  5  ALU opcode of instruction in X.
- x_rd  in  5  destination register of instruction in X.
- flush  in  1  synchronous squash of the X instruction (branch/jump taken).
- md_ready  in  1  multdiv unit result ready (single-cycle pulse).
- md_exception  in  1  multdiv unit overflow / divide-by-zero.
- md_result  in  32  multdiv unit result.
- ctrl_mult  out  1  start-multiply pulse to multdiv unit.
- ctrl_div  out  1  start-divide pulse to multdiv unit.
- stall  out  1  hold PC, F/D, D/X latches.
- res_valid  out  1  result packet valid (one cycle).
- res_data  out  32  latched result.
- res_ovf  out  1  latched exception; feeds the exception checker's multdiv_ovf.
- res_rd  out  5  latched destination register.
- res_is_div  out  1  1 = div, 0 = mult.

Behaviour:
- Decode:
  - is_mul = (x_op==00000 && x_aluop==00110).
  - is_div = (x_op==00000 && x_aluop==00111).
  - is_md = is_mul | is_div.
- States: IDLE, START, WAIT, DONE. All are 2-bit registered.
- Reset, asynchronous: state=IDLE, counter=0, res_data=0, res_ovf=0, res_rd=0, res_is_div=0. All outputs read 0 while reset is high.
- IDLE:
  - If is_md & ~flush: stall=1 combinationally in the same cycle, latch x_rd and is_div, go to START.
  - Otherwise stall=0 and stay in IDLE.
- START:
  - ctrl_mult=~is_div_latched, ctrl_div=is_div_latched, each exactly one cycle.
  - stall=1, counter←0, go to WAIT.
  - md_ready is ignored in this state.
- WAIT:
  - stall=1, counter increments each cycle.
  - If md_ready: res_data←md_result, res_ovf←md_exception, go to DONE.
  - Else if counter==TIMEOUT-1: res_data←0, res_ovf←1, go to DONE.
  - md_ready takes priority over timeout in the same cycle.
- DONE:
  - res_valid=1, stall=0; the pipeline advances at the end of this cycle. Go to IDLE unconditionally.
  - res_* holds its value until the next capture.
- Latency: detection at cycle 0; ctrl pulse at cycle 1; earliest res_valid at cycle 3 (md_ready seen at cycle 2).
  - Stall cycles = 2 + (WAIT cycles).
- Back-to-back mul/div: the second one is detected in the first IDLE cycle after DONE, with no bubble beyond that cycle. A mul/div held in X during DONE is not re-issued, because IDLE re-decodes only after X advances.
- flush:
  - In IDLE: suppresses detection.
  - In START/WAIT: go to IDLE next cycle. No res_valid. res_* unchanged. Any late md_ready is ignored in IDLE.
  - In DONE: res_valid is still asserted (the instruction has completed).
- Reset mid-operation: immediate return to IDLE. The multdiv unit is restarted only by the next ctrl pulse.
- ctrl_mult and ctrl_div are never high simultaneously, and are never high outside START.

Decomposition:
- Shared package (processor_defs):
  - OP_ALU=00000, ALUOP_MUL=00110, ALUOP_DIV=00111.
  - FSM state encodings IDLE=00, START=01, WAIT=10, DONE=11.
- One natural sub-module: md_watchdog, a counter with clear, enable and terminal-count compare, parameterised by TIMEOUT/CNT_W.

Test Plan:
- mul, rd=5, md_ready at cycle 34 with md_result=0x0000_0A00, md_exception=0 → ctrl_mult pulse at cycle 1, stall high cycles 0–34, res_valid at 35, res_data=0xA00, res_ovf=0, res_rd=5, res_is_div=0.
- div, rd=7, md_ready after 3 cycles with md_exception=1 (div by zero) → ctrl_div only, res_ovf=1, res_is_div=1, res_rd=7, exactly one res_valid.
- mul with md_ready never asserted, TIMEOUT=64 → forced DONE after 64 WAIT cycles, res_data=0, res_ovf=1, stall drops in DONE.
- flush asserted at WAIT cycle 10, md_ready at cycle 20 → state IDLE at cycle 11, no res_valid, res_* unchanged, stall=0 from cycle 11.
- Back-to-back mul then div → two distinct ctrl pulses, two res_valid pulses, the first mul not re-issued during its DONE cycle.
- reset pulsed asynchronously mid-WAIT → all outputs 0 immediately; a subsequent mul completes normally.
